// File: rtl/msa_update_controller.sv
// msa_update_controller: shadow/live MSA attribute registers with stream-safe commit and post-commit quiesce.
// Live values load atomically from shadow only at an active-line BS, or after a timeout if the stream stalls.
module msa_update_controller #(
    parameter int TIMEOUT_CYCLES = 2097152,
    parameter bit START_ENABLED  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr_en,
    input  logic [3:0]  cfg_addr,
    input  logic [23:0] cfg_wr_data,
    input  logic        cfg_commit,
    input  logic        cfg_enable,
    output logic        cfg_busy,
    output logic        cfg_wr_err,
    output logic        commit_forced,
    input  logic [72:0] in_data,
    output logic        msa_active,
    output logic [23:0] M_value,
    output logic [23:0] N_value,
    output logic [11:0] H_visible,
    output logic [11:0] V_visible,
    output logic [11:0] H_total,
    output logic [11:0] V_total,
    output logic [11:0] H_sync_width,
    output logic [11:0] V_sync_width,
    output logic [11:0] H_start,
    output logic [11:0] V_start,
    output logic [14:0] msa_flags
);
    localparam logic [8:0]  BS        = 9'b110111100;
    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [14:0] FLAGS_RST = 15'h2000;
    typedef enum logic [1:0] {IDLE, PENDING, COMMIT, QUIESCE} state_t;
    state_t state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [5:0][23:0] sh_q, live_q;
    logic [14:0] shf_q, livef_q;
    logic s1_q, last_vb_q, last_vb_d, forced_q, forced_d, en_q, en_d, act_q, err_q;
    logic slot0, vb0, vb1, safe, prev0, vb_exit, wr_ok, unused_bits;
    assign unused_bits = ^in_data[72:18];
    assign slot0 = in_data[8:0] == BS;
    assign vb0 = in_data[9];
    assign vb1 = in_data[0];
    assign safe = (slot0 && !vb0) || (s1_q && !vb1);
    // a slot1 BS from the previous cycle precedes this cycle's slot0 BS in stream order
    assign prev0 = s1_q ? vb1 : last_vb_q;
    assign vb_exit = (s1_q && vb1 && !last_vb_q) || (slot0 && vb0 && !prev0);
    assign last_vb_d = slot0 ? vb0 : (s1_q ? vb1 : last_vb_q);
    assign cfg_busy = state_q != IDLE;
    assign wr_ok = cfg_wr_en && !cfg_busy;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        forced_d = forced_q;
        en_d     = en_q;
        case (state_q)
            IDLE: if (cfg_commit) begin
                state_d = PENDING;
                cnt_d   = '0;
            end
            PENDING: begin
                cnt_d = cnt_q + 1'b1;
                if (safe) begin
                    state_d  = COMMIT;
                    forced_d = 1'b0;
                end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = COMMIT;
                    forced_d = 1'b1;
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                en_d    = 1'b1;
                state_d = QUIESCE;
            end
            default: state_d = vb_exit ? IDLE : QUIESCE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            s1_q      <= 1'b0;
            last_vb_q <= 1'b1;
            forced_q  <= 1'b0;
            en_q      <= START_ENABLED;
            act_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_q      <= in_data[17:9] == BS;
            last_vb_q <= last_vb_d;
            forced_q  <= forced_d;
            en_q      <= en_d;
            act_q     <= cfg_enable && en_d && (state_d != QUIESCE);
            err_q     <= cfg_busy && (cfg_wr_en || cfg_commit);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q    <= '0;
            shf_q   <= FLAGS_RST;
            live_q  <= '0;
            livef_q <= FLAGS_RST;
        end else begin
            if (wr_ok && cfg_addr < 4'd6) sh_q[cfg_addr[2:0]] <= cfg_wr_data;
            if (wr_ok && cfg_addr == 4'd6) shf_q <= cfg_wr_data[14:0];
            if (state_q == COMMIT) begin
                live_q  <= sh_q;
                livef_q <= shf_q;
            end
        end
    end
    assign cfg_wr_err    = err_q;
    assign commit_forced = forced_q;
    assign msa_active    = act_q;
    assign M_value       = live_q[0];
    assign N_value       = live_q[1];
    assign H_visible     = live_q[2][11:0];
    assign V_visible     = live_q[2][23:12];
    assign H_total       = live_q[3][11:0];
    assign V_total       = live_q[3][23:12];
    assign H_sync_width  = live_q[4][11:0];
    assign V_sync_width  = live_q[4][23:12];
    assign H_start       = live_q[5][11:0];
    assign V_start       = live_q[5][23:12];
    assign msa_flags     = livef_q;
endmodule

// File: doc/msa_update_controller.md
Name: msa_update_controller

Overview:
Owns the Main Stream Attribute values and the MSA "active" enable that drive the four-lane MSA inserter. A host writes new video-mode values into shadow registers and then requests a commit. The block monitors the 4-lane symbol stream and copies shadow to live only at a safe point, so the inserter never emits an MSA packet mixing old and new values. After a commit, MSA transmission is suppressed until the next vertical blank starts.

Parameters:
TIMEOUT_CYCLES, 2097152, cycles to wait in PENDING for a safe point before forcing a commit (stream stalled).
START_ENABLED, 0, reset value of the internal enable bit that gates msa_active.

Ports:
clk  in  1  symbol clock, shared with the MSA inserter
reset  in  1  asynchronous, active-high; all state to reset values
cfg_wr_en  in  1  host write strobe, one word per cycle
cfg_addr  in  4  shadow register address
cfg_wr_data  in  24  write data
cfg_commit  in  1  single-cycle pulse: request shadow->live transfer
cfg_enable  in  1  level; MSA transmission allowed when 1
cfg_busy  out  1  high while a commit is pending or executing
cfg_wr_err  out  1  1-cycle pulse: write or commit rejected because busy
commit_forced  out  1  sticky; set when a commit happened via timeout; cleared by the next normal commit
in_data  in  73  monitored 4-lane symbol stream (9-bit symbols; lane0 = [8:0], [17:9])
msa_active  out  1  to the inserter's active input
M_value, N_value  out  24 each  live
H_visible, V_visible, H_total, V_total  out  12 each  live
H_sync_width, V_sync_width, H_start, V_start  out  12 each  live
msa_flags  out  15  live, same layout as shadow register 6

Behaviour:
- Register map (write-only shadow; addresses 7-15 ignored without error):
  - 0: M[23:0]
  - 1: N[23:0]
  - 2: {V_visible, H_visible}
  - 3: {V_total, H_total}
  - 4: {V_sync_width, H_sync_width}
  - 5: {V_start, H_start}
  - 6: [0] H_vsync_active_high, [1] V_vsync_active_high, [2] sync_clock, [3] YCCnRGB, [4] 422n444, [5] range_reduced, [6] interlaced_even, [7] YCC_709, [9:8] 3d indicators, [14:10] bits_per_colour, [23:15] ignored.
- Reset values:
  - Shadow and live registers all 0, except bits_per_colour = 8.
  - msa_active = 0, cfg_busy = 0, cfg_wr_err = 0, commit_forced = 0, state = IDLE.
- BS detection (BS = 9'b110111100):
  - Lane0 slot0 (in_data[8:0] == BS): VB-ID bit = in_data[9], same cycle.
  - Lane0 slot1 (in_data[17:9] == BS): VB-ID bit = in_data[0] on the following cycle, via a registered flag.
  - Both slots may carry BS in consecutive cycles; each detection is evaluated independently.
- Safe point: a detected BS whose VB-ID bit is 0 (active line). The inserter only fires on vblank BS and finishes within 8 cycles, so no MSA is in flight at this point.
- State machine:
  - IDLE: writes update shadow in the cycle after cfg_wr_en. cfg_commit moves to PENDING, and cfg_busy rises the next cycle.
  - PENDING: each cycle, increment the timeout counter (reset to 0 on entry). On a safe point, go to COMMIT. If the counter reaches TIMEOUT_CYCLES-1, go to COMMIT and set commit_forced.
  - COMMIT (1 cycle): copy all shadow to live; clear the timeout counter; go to QUIESCE.
  - QUIESCE: msa_active held 0. Go to IDLE on the first detected BS with VB-ID bit 1 that follows a BS with VB-ID bit 0 (start of the next vblank). cfg_busy drops on entry to IDLE.
- While cfg_busy = 1: cfg_wr_en and cfg_commit are ignored (shadow unchanged) and cfg_wr_err pulses for 1 cycle per rejected request. A write and a commit in the same IDLE cycle: the write lands in shadow before the copy.
- msa_active = cfg_enable AND enable_bit AND (state != QUIESCE), registered (1-cycle latency from cfg_enable). enable_bit is set by the first completed commit; START_ENABLED presets it.
- Live outputs change only in the cycle after COMMIT and are otherwise stable.
- Reset asserted mid-commit returns everything to reset values immediately. There is no partial live update: the copy is a single-cycle atomic register load.

Test Plan:
- Write regs 0-6 (M=0x012345, H_total=2200, bpc=8), commit; active-line BS at cycle 40 -> live values update at cycle 42, cfg_busy 1 from commit+1 until first vblank BS; msa_active 0 throughout QUIESCE.
- Commit issued during vblank lines only (VB-ID=1) -> no update until the first VB-ID=0 BS, then normal sequence.
- BS in slot1 with VB-ID=0 in in_data[0] the next cycle -> treated as safe point; same as a slot0 case but one cycle later.
- No BS after commit, TIMEOUT_CYCLES=64 -> commit at cycle 64, commit_forced=1; next normal commit clears it.
- Write to reg 3 while busy -> cfg_wr_err pulse, shadow unchanged (verify via a later commit).
- Assert reset during PENDING -> all outputs at reset values next edge, bits_per_colour=8, msa_active=0.
